// File: rtl/ntt_fifo_reader.sv
// Drains one NTT polynomial buffer as (coeff[k], coeff[k+N/2]) pairs through a
// two-entry output queue, with one-cycle read latency and credit-based issue.
module ntt_fifo_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  empty,
  output logic [ADDR_WIDTH-1:0] rd_addrA,
  output logic [ADDR_WIDTH-1:0] rd_addrB,
  input  logic [DATA_WIDTH-1:0] rd_dA,
  input  logic [DATA_WIDTH-1:0] rd_dB,
  output logic                  rd_finish,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_last,
  output logic                  busy
);

  localparam int KW = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic                  settle_q, settle_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] q0_a_q, q0_a_d, q0_b_q, q0_b_d;
  logic [DATA_WIDTH-1:0] q1_a_q, q1_a_d, q1_b_q, q1_b_d;
  logic                  q0_last_q, q0_last_d, q1_last_q, q1_last_d;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [1:0]            occ;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = pend_q;
  // Slots committed after this cycle's pop; a new read may claim one if free.
  assign occ       = cnt_q + {1'b0, pend_q} - {1'b0, pop};

  assign rd_addrA  = {1'b0, k_q};
  assign rd_addrB  = {1'b1, k_q};
  assign out_a     = q0_a_q;
  assign out_b     = q0_b_q;
  assign out_last  = q0_last_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      settle_q    <= 1'b0;
      cnt_q       <= 2'd0;
      q0_a_q      <= '0;
      q0_b_q      <= '0;
      q0_last_q   <= 1'b0;
      q1_a_q      <= '0;
      q1_b_q      <= '0;
      q1_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      q0_a_q      <= q0_a_d;
      q0_b_q      <= q0_b_d;
      q0_last_q   <= q0_last_d;
      q1_a_q      <= q1_a_d;
      q1_b_q      <= q1_b_d;
      q1_last_q   <= q1_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !empty && !settle_q) state_d = READ;
      READ:    if (issue && (k_q == {KW{1'b1}})) state_d = DRAIN;
      DRAIN:   if (!pend_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_finish = (state_q == IDLE);
    busy      = (state_q != IDLE);
    issue     = (state_q == READ) && (occ < 2'd2);
  end

  always_comb begin
    k_d         = issue ? k_q + 1'b1 : k_q;
    pend_d      = issue;
    pend_last_d = issue && (k_q == {KW{1'b1}});
    // Empty is ignored for one IDLE cycle so the sink sees the rd_finish edge.
    settle_d    = (state_q == DRAIN) && !pend_q;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    q0_a_d      = q0_a_q;
    q0_b_d      = q0_b_q;
    q0_last_d   = q0_last_q;
    q1_a_d      = q1_a_q;
    q1_b_d      = q1_b_q;
    q1_last_d   = q1_last_q;
    if (pop) begin
      q0_a_d    = q1_a_q;
      q0_b_d    = q1_b_q;
      q0_last_d = q1_last_q;
    end
    if (push) begin
      if ((cnt_q == 2'd0) || (pop && cnt_q == 2'd1)) begin
        q0_a_d    = rd_dA;
        q0_b_d    = rd_dB;
        q0_last_d = pend_last_q;
      end else begin
        q1_a_d    = rd_dA;
        q1_b_d    = rd_dB;
        q1_last_d = pend_last_q;
      end
    end
  end

endmodule

// File: doc/ntt_fifo_reader.md
NTT_FIFO_READER -- requirements
Module: ntt_fifo_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: polynomial buffer address width; N = 2**ADDR_WIDTH coefficients.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: coefficient width.
REQ-003 SHALL have one clock, clk, and one reset, rstn; reset is asynchronous and active-low.
REQ-004 SHALL provide the following ports, clock and reset first, one per line:
  clk  in  1  clock, all state on rising edge
  rstn  in  1  asynchronous active-low reset
  enable  in  1  permission to start draining a buffer
  empty  in  1  FIFO sink-side empty flag
  rd_addrA  out  ADDR_WIDTH  lower-half read address
  rd_addrB  out  ADDR_WIDTH  upper-half read address
  rd_dA  in  DATA_WIDTH  data for rd_addrA, one cycle after the address
  rd_dB  in  DATA_WIDTH  data for rd_addrB, one cycle after the address
  rd_finish  out  1  level, high = not reading; 0->1 edge releases the buffer
  out_valid  out  1  output pair valid
  out_ready  in  1  downstream accepts pair
  out_a  out  DATA_WIDTH  coeff[k]
  out_b  out  DATA_WIDTH  coeff[k+N/2]
  out_last  out  1  marks pair k = N/2-1
  busy  out  1  state != IDLE

Function
REQ-005 SHALL implement states IDLE, READ and DRAIN.
REQ-006 IDLE: rd_finish=1, rd_addrA=0, rd_addrB=N/2; empty SHALL be ignored in the first IDLE cycle after leaving DRAIN (one-cycle settle).
REQ-007 IDLE -> READ when enable=1 and empty=0; rd_finish SHALL go 0 in the cycle READ is entered.
REQ-008 The read latency is fixed at one cycle: an address issued in cycle t SHALL have its data captured from rd_dA/rd_dB at the rising edge ending cycle t+1.
REQ-009 READ SHALL issue an address pair in a cycle only if (output queue count + in-flight reads) < 2; after each issue rd_addrA and rd_addrB SHALL each increment by 1.
REQ-010 rd_addrA/rd_addrB SHALL remain unchanged in READ cycles with no issue.
REQ-011 READ -> DRAIN on the cycle that issues rd_addrB = all ones.
REQ-012 DRAIN -> IDLE when in-flight = 0 and the final pair is in the output queue; rd_finish SHALL rise on IDLE entry, never before the last data capture.
REQ-013 The output queue SHALL hold 2 entries in FIFO order; out_valid = queue non-empty; a pop occurs on out_valid & out_ready.
REQ-014 out_a, out_b and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 Pairs SHALL leave in order k = 0..N/2-1 with out_a=coeff[k] and out_b=coeff[k+N/2]; out_last=1 only on k=N/2-1.
REQ-016 With out_ready held at 1, throughput SHALL be one pair per cycle after the first pair; the first pair SHALL appear 2 cycles after READ entry.
REQ-017 Queue draining into IDLE/next READ SHALL continue independently; pairs of consecutive polynomials SHALL not interleave or be lost.
REQ-018 enable deasserted during READ/DRAIN SHALL not abort the current polynomial; it gates only IDLE -> READ.

Reset
REQ-019 While rstn=0, SHALL force, immediately and without clk: state=IDLE, rd_addrA=0, rd_addrB=N/2, rd_finish=1, out_valid=0, out_last=0, out_a=0, out_b=0, busy=0, queue and in-flight cleared.
REQ-020 After reset mid-operation, the next polynomial SHALL start from k=0; the partially read buffer is not released by an rd_finish edge.

Verification (bench: ADDR_WIDTH=4, N=16, coeff[i]=0x100+i)
REQ-021 enable=1, empty=0, out_ready=1 -> 8 consecutive pairs (0x100,0x108)..(0x107,0x10F), out_last on the 8th, rd_finish low from READ entry until one cycle after the last capture.
REQ-022 out_ready alternating 0/1 (then random) -> the same 8 pairs, no loss/duplication, outputs stable while stalled, at most 2 reads outstanding.
REQ-023 empty=1 with enable=1 for 50 cycles -> IDLE held, rd_finish=1, out_valid=0, rd_addrA=0, rd_addrB=8.
REQ-024 rstn pulsed low after 3 pairs have been accepted -> all outputs at reset values asynchronously; after release with empty=0 the first pair is again (0x100,0x108).
REQ-025 empty held 0 across two polynomials -> rd_finish high for exactly 2 cycles between them, 16 pairs in order, out_last on pairs 8 and 16.
REQ-026 enable dropped mid-READ -> current polynomial completes with all 8 pairs, then the block stays in IDLE.
